example_apb_slave: RTL and testbench



---
 rtl/example_apb_slave_if.sv | 38 +++
 rtl/example_apb_slave.sv | 164 ++++++++++++++++
 tb/tb_example_apb_slave.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/example_apb_slave_if.sv
// ---------------------------------------------------------------------------
// example_apb_slave_if
//   APB bus bundle shared by the register slave and whatever drives it.
//
//   psel     master->slave  peripheral select
//   penable  master->slave  access phase
//   pwrite   master->slave  1 = write, 0 = read
//   paddr    master->slave  word address
//   pwdata   master->slave  write data
//   pstrb    master->slave  byte write strobes
//   prdata   slave->master  read data (meaningful only with pready)
//   pready   slave->master  transfer completion
//   pslverr  slave->master  error response (meaningful only with pready)
// ---------------------------------------------------------------------------
interface example_apb_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/example_apb_slave.sv
// ---------------------------------------------------------------------------
// example_apb_slave
//   APB register slave holding nine registers reg0..reg8 at word addresses
//   0..8, with a programmable number of wait states per transfer.
//
//   clk        clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   apb        APB slave port (see example_apb_slave_if)
//   regs       whole register bank, reg0 in the MSBs down to reg8 in the LSBs
//              (reg0,1,3,4,5,6: 32 bits, reg2: 6, reg7: 12, reg8: 8)
//   wr_strobe  one-cycle pulse, bit n set in the cycle regn shows a new value
// ---------------------------------------------------------------------------
module example_apb_slave #(
  parameter int WAIT_STATES = 0,   // 0..7
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32   // only 32 is supported
) (
  input  logic                 clk,
  input  logic                 reset_n,
  example_apb_slave_if.slave   apb,
  output logic [217:0]         regs,
  output logic [8:0]           wr_strobe
);

  localparam int NUM_REGS  = 9;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  function automatic int reg_width(input int n);
    case (n)
      2:       return 6;
      7:       return 12;
      8:       return 8;
      default: return 32;
    endcase
  endfunction

  // Bit position of regn inside the packed bank; higher-numbered registers
  // sit below it.
  function automatic int reg_lsb(input int n);
    int lsb;
    lsb = 0;
    for (int k = n + 1; k < NUM_REGS; k++) lsb += reg_width(k);
    return lsb;
  endfunction

  function automatic logic [31:0] reg_reset(input int n);
    case (n)
      1, 2, 3: return 32'd1;
      4:       return 32'd12;
      default: return 32'd0;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Transfer FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Only a proper setup phase starts a transfer; a stray access phase
        // without setup (e.g. still held after a reset abort) is ignored.
        if (apb.psel && !apb.penable) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 3'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          // Counter reaching zero on this edge means the next cycle is the
          // completion cycle, giving exactly WAIT_STATES low-pready cycles.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Bus responses and decode
  // ------------------------------------------------------------------
  logic                  addr_ok;
  logic                  wr_commit;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0]   wr_strobe_q;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] rd_word [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign addr_ok   = apb.paddr < ADDR_WIDTH'(NUM_REGS);
  assign apb.pready  = (state_q == DONE) && apb.psel && apb.penable;
  assign apb.pslverr = apb.pready && !addr_ok;
  assign wr_commit   = apb.pready && apb.pwrite && addr_ok;

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (apb.paddr == ADDR_WIDTH'(n)) rd_mux = rd_word[n];
    end
  end

  assign apb.prdata = (apb.pready && !apb.pwrite && addr_ok) ? rd_mux : '0;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bmask
    assign byte_mask[8*gi +: 8] = {8{apb.pstrb[gi]}};
  end

  // ------------------------------------------------------------------
  // Register bank
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam int W   = reg_width(gi);
    localparam int LSB = reg_lsb(gi);

    logic [W-1:0] val_q, val_d;

    // Byte merge against the current value, truncated to the register width.
    assign val_d = (val_q & ~byte_mask[W-1:0]) | (apb.pwdata[W-1:0] & byte_mask[W-1:0]);
    assign wr_sel[gi]       = wr_commit && (apb.paddr == ADDR_WIDTH'(gi));
    assign rd_word[gi]      = DATA_WIDTH'(val_q);
    assign regs[LSB +: W]   = val_q;

    if ((gi == 5) || (gi == 6)) begin : g_norst
      // reg5/reg6 deliberately keep their contents across reset.
      always_ff @(posedge clk) begin
        if (wr_sel[gi]) val_q <= val_d;
      end
    end else begin : g_rst
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        val_q <= W'(reg_reset(gi));
        else if (wr_sel[gi]) val_q <= val_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_strobe_q <= '0;
    else          wr_strobe_q <= wr_sel;
  end

  assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_example_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_example_apb_slave
//   Two slaves (WAIT_STATES 0 and 3) share one master. Every transfer is
//   held until the slower slave completes, so both commit every transfer
//   exactly once and one register model serves both.
// ---------------------------------------------------------------------------
module tb_example_apb_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [217:0] regs0, regs3;
  logic [8:0]   wrs0, wrs3;

  example_apb_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus0 ();
  example_apb_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();

  assign bus0.psel = psel;     assign bus3.psel = psel;
  assign bus0.penable = penable; assign bus3.penable = penable;
  assign bus0.pwrite = pwrite; assign bus3.pwrite = pwrite;
  assign bus0.paddr = paddr;   assign bus3.paddr = paddr;
  assign bus0.pwdata = pwdata; assign bus3.pwdata = pwdata;
  assign bus0.pstrb = pstrb;   assign bus3.pstrb = pstrb;

  example_apb_slave #(.WAIT_STATES(0), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .apb(bus0), .regs(regs0), .wr_strobe(wrs0));
  example_apb_slave #(.WAIT_STATES(3), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .apb(bus3), .regs(regs3), .wr_strobe(wrs3));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] model [9];
  bit          known [9];

  function automatic int width_of(input int n);
    if (n == 2) return 6;
    if (n == 7) return 12;
    if (n == 8) return 8;
    return 32;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st, input int n);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    if (width_of(n) < 32) r = r & ((32'd1 << width_of(n)) - 32'd1);
    return r;
  endfunction

  task automatic model_reset();
    model[0] = 32'd0; model[1] = 32'd1; model[2] = 32'd1; model[3] = 32'd1;
    model[4] = 32'd12; model[7] = 32'd0; model[8] = 32'd0;
    foreach (known[i]) if (i != 5 && i != 6) known[i] = 1'b1;
  endtask

  function automatic logic [217:0] exp_regs();
    return {model[0], model[1], model[2][5:0], model[3], model[4], model[5], model[6],
            model[7][11:0], model[8][7:0]};
  endfunction

  function automatic logic [217:0] regs_mask();
    logic [31:0] m5, m6;
    m5 = known[5] ? 32'hFFFF_FFFF : 32'h0;
    m6 = known[6] ? 32'hFFFF_FFFF : 32'h0;
    return {32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m5, m6,
            12'hFFF, 8'hFF};
  endfunction

  // ---------------- bus driver ----------------
  logic [31:0] rd0, rd3;
  logic        err0, err3;
  int          lat0, lat3;
  logic [8:0]  s0_after, s0_other, s0_idle, s3_idle;
  bit          early_bad, idle_bad;

  // Setup then access phases until the slow slave completes. Ends at the
  // negedge of that completion cycle with the bus still driven, so a
  // following call is back-to-back.
  task automatic xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] st);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    lat0 = 0; lat3 = 0; n = 1; s0_after = '0; s0_other = '0; early_bad = 1'b0;
    rd0 = 'x; rd3 = 'x; err0 = 1'bx; err3 = 1'bx;
    forever begin
      @(negedge clk);
      if (lat0 != 0 && n == lat0 + 1) s0_after = wrs0;
      else s0_other = s0_other | wrs0;
      if (bus0.pready === 1'b1) begin
        if (lat0 == 0) begin lat0 = n; rd0 = bus0.prdata; err0 = bus0.pslverr; end
        else early_bad = 1'b1;
      end else if (bus0.prdata !== 32'h0 || bus0.pslverr !== 1'b0) early_bad = 1'b1;
      if (bus3.pready === 1'b1) begin
        lat3 = n; rd3 = bus3.prdata; err3 = bus3.pslverr;
      end else if (bus3.prdata !== 32'h0 || bus3.pslverr !== 1'b0) early_bad = 1'b1;
      if (lat3 != 0 || n >= 20) break;
      @(posedge clk); #1;
      n++;
    end
    $display("xfer %s a=%0d d=%08h st=%h | dut0 lat=%0d rd=%08h err=%b | dut3 lat=%0d rd=%08h err=%b",
             wr ? "WR" : "RD", a, d, st, lat0, rd0, err0, lat3, rd3, err3);
    if (wr && a < 4'd9) begin
      model[a] = merge(model[a], d, st, int'(a));
      known[a] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    s0_idle = wrs0; s3_idle = wrs3;
    idle_bad = (bus0.pready !== 1'b0) || (bus3.pready !== 1'b0) ||
               (bus0.prdata !== 32'h0) || (bus3.prdata !== 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0]  addrs [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    logic [31:0] vals  [7] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd12, 32'd0, 32'd0};
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_cmp++; if ({bus0.pready, bus3.pready, bus0.pslverr, bus3.pslverr} !== 4'b0) begin
      n_err++; $display("FAIL reset_ready_err: got %b want 0000",
                        {bus0.pready, bus3.pready, bus0.pslverr, bus3.pslverr}); end
    n_cmp++; if ({bus0.prdata, bus3.prdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_prdata: got %h/%h want 0", bus0.prdata, bus3.prdata); end
    n_cmp++; if ({wrs0, wrs3} !== 18'h0) begin
      n_err++; $display("FAIL reset_strobe: got %h/%h want 0", wrs0, wrs3); end
    n_cmp++; if (((regs0 & regs_mask()) !== (exp_regs() & regs_mask())) ||
                 ((regs3 & regs_mask()) !== (exp_regs() & regs_mask()))) begin
      n_err++; $display("FAIL reset_regs: got %h / %h want %h", regs0, regs3, exp_regs()); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      xfer(1'b0, addrs[i], $urandom, 4'($urandom));
      n_cmp++; if (rd0 !== vals[i] || rd3 !== vals[i]) begin
        n_err++; $display("FAIL reset_read a=%0d: got %h/%h want %h", addrs[i], rd0, rd3, vals[i]); end
      n_cmp++; if (err0 !== 1'b0 || err3 !== 1'b0) begin
        n_err++; $display("FAIL reset_read_err a=%0d: got %b/%b want 0", addrs[i], err0, err3); end
      n_cmp++; if (lat0 != 1 || lat3 != 4) begin
        n_err++; $display("FAIL reset_read_lat a=%0d: got %0d/%0d want 1/4", addrs[i], lat0, lat3); end
    end
    idle_cycle();
  endtask

  task automatic test_width_trunc();
    xfer(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF);
    n_cmp++; if (s0_after !== 9'h004 || s0_other !== 9'h000) begin
      n_err++; $display("FAIL trunc_strobe0: got %h (other %h) want 004", s0_after, s0_other); end
    idle_cycle();
    n_cmp++; if (s3_idle !== 9'h004 || s0_idle !== 9'h000) begin
      n_err++; $display("FAIL trunc_strobe3: got %h (dut0 %h) want 004", s3_idle, s0_idle); end
    idle_cycle();
    n_cmp++; if (s3_idle !== 9'h000) begin
      n_err++; $display("FAIL trunc_strobe_len: got %h want 000", s3_idle); end
    xfer(1'b0, 4'd2, $urandom, 4'hF);
    n_cmp++; if (rd0 !== 32'h0000_003F || rd3 !== 32'h0000_003F) begin
      n_err++; $display("FAIL trunc_read: got %h/%h want 0000003f", rd0, rd3); end
    idle_cycle();
    n_cmp++; if (s3_idle !== 9'h000 || s0_other !== 9'h000) begin
      n_err++; $display("FAIL read_no_strobe: got %h/%h want 0", s0_other, s3_idle); end
  endtask

  task automatic test_byte_strobe();
    xfer(1'b1, 4'd0, 32'h1122_3344, 4'hF);
    idle_cycle();
    xfer(1'b1, 4'd0, 32'hAABB_CCDD, 4'b0101);
    idle_cycle();
    n_cmp++; if (s3_idle !== 9'h001) begin
      n_err++; $display("FAIL bytes_strobe: got %h want 001", s3_idle); end
    xfer(1'b0, 4'd0, $urandom, 4'h0);
    n_cmp++; if (rd0 !== 32'h11BB_33DD || rd3 !== 32'h11BB_33DD) begin
      n_err++; $display("FAIL bytes_read: got %h/%h want 11bb33dd", rd0, rd3); end
    idle_cycle();
  endtask

  task automatic test_error();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] a;
      bit wr;
      a  = 4'($urandom_range(15, 9));
      wr = (i % 2 == 0);
      xfer(wr, a, $urandom, 4'hF);
      n_cmp++; if (err0 !== 1'b1 || err3 !== 1'b1 || rd0 !== 32'h0 || rd3 !== 32'h0) begin
        n_err++; $display("FAIL error_resp a=%0d: got err %b/%b rd %h/%h want 1/1 0/0",
                          a, err0, err3, rd0, rd3); end
      n_cmp++; if (lat0 != 1 || lat3 != 4) begin
        n_err++; $display("FAIL error_lat a=%0d: got %0d/%0d want 1/4", a, lat0, lat3); end
      idle_cycle();
      n_cmp++; if (s0_after !== 9'h0 || s3_idle !== 9'h0) begin
        n_err++; $display("FAIL error_strobe a=%0d: got %h/%h want 0", a, s0_after, s3_idle); end
      n_cmp++; if (((regs0 & regs_mask()) !== (exp_regs() & regs_mask())) ||
                   ((regs3 & regs_mask()) !== (exp_regs() & regs_mask()))) begin
        n_err++; $display("FAIL error_regs a=%0d: got %h / %h want %h", a, regs0, regs3, exp_regs()); end
    end
  endtask

  task automatic test_reset_abort();
    bit bad;
    xfer(1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF);
    idle_cycle();
    xfer(1'b1, 4'd6, $urandom, 4'hF);
    idle_cycle();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = $urandom; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus0.pready !== 1'b0 || bus3.pready !== 1'b0) begin
      n_err++; $display("FAIL abort_ready: got %b/%b want 0/0", bus0.pready, bus3.pready); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.pready !== 1'b0 || bus3.pready !== 1'b0 || wrs0 !== 9'h0 || wrs3 !== 9'h0) bad = 1'b1;
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    n_cmp++; if (bad) begin
      n_err++; $display("FAIL abort_resume: got activity after release want none"); end
    xfer(1'b0, 4'd4, $urandom, 4'hF);
    n_cmp++; if (rd0 !== 32'd12 || rd3 !== 32'd12) begin
      n_err++; $display("FAIL abort_reg4: got %h/%h want 0000000c", rd0, rd3); end
    xfer(1'b0, 4'd5, $urandom, 4'hF);
    n_cmp++; if (rd0 !== 32'hDEAD_BEEF || rd3 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL abort_reg5: got %h/%h want deadbeef", rd0, rd3); end
    idle_cycle();
    n_cmp++; if (((regs0 & regs_mask()) !== (exp_regs() & regs_mask())) ||
                 ((regs3 & regs_mask()) !== (exp_regs() & regs_mask()))) begin
      n_err++; $display("FAIL abort_regs: got %h / %h want %h", regs0, regs3, exp_regs()); end
  endtask

  task automatic test_protocol_violation();
    bit bad;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = $urandom; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0;
    @(negedge clk);
    bad = (bus0.pready !== 1'b0) || (bus3.pready !== 1'b0) || (wrs0 !== 9'h0) || (wrs3 !== 9'h0);
    // Next setup one cycle later: only accepted on time if the drop returned to IDLE.
    xfer(1'b0, 4'd1, $urandom, 4'hF);
    n_cmp++; if (bad || s0_other !== 9'h0) begin
      n_err++; $display("FAIL viol_commit: got activity (strobe %h) want none", s0_other); end
    n_cmp++; if (rd0 !== model[1] || rd3 !== model[1]) begin
      n_err++; $display("FAIL viol_read: got %h/%h want %h", rd0, rd3, model[1]); end
    n_cmp++; if (lat0 != 1 || lat3 != 4) begin
      n_err++; $display("FAIL viol_lat: got %0d/%0d want 1/4", lat0, lat3); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [3:0]  a;
      logic [31:0] exp;
      a = 4'($urandom_range(8, 0));
      xfer(1'b1, a, $urandom, 4'($urandom_range(15, 1)));
      n_cmp++; if (s0_after !== (9'd1 << a)) begin
        n_err++; $display("FAIL b2b_strobe a=%0d: got %h want %h", a, s0_after, 9'd1 << a); end
      exp = model[a];
      xfer(1'b0, a, $urandom, 4'hF);
      n_cmp++; if (rd0 !== exp || rd3 !== exp || lat0 != 1 || lat3 != 4) begin
        n_err++; $display("FAIL b2b_read a=%0d: got %h/%h lat %0d/%0d want %h lat 1/4",
                          a, rd0, rd3, lat0, lat3, exp); end
    end
    idle_cycle();
    n_cmp++; if (idle_bad) begin
      n_err++; $display("FAIL b2b_idle: got pready/prdata active when idle want quiet"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [3:0]  a;
      logic [31:0] d, exp_rd;
      logic [3:0]  st;
      logic [8:0]  exp_s;
      wr = 1'($urandom);
      a  = 4'($urandom_range(15, 0));
      d  = $urandom;
      st = 4'($urandom);
      if (a < 4'd9 && !known[a]) wr = 1'b1;
      exp_rd = (a < 4'd9 && !wr) ? model[a] : 32'h0;
      exp_s  = (wr && a < 4'd9) ? (9'd1 << a) : 9'h0;
      xfer(wr, a, d, st);
      n_cmp++; if (err0 !== (a >= 4'd9) || err3 !== (a >= 4'd9) || lat0 != 1 || lat3 != 4) begin
        n_err++; $display("FAIL rnd_resp a=%0d: got err %b/%b lat %0d/%0d want %b lat 1/4",
                          a, err0, err3, lat0, lat3, a >= 4'd9); end
      if (!wr) begin
        n_cmp++; if (rd0 !== exp_rd || rd3 !== exp_rd) begin
          n_err++; $display("FAIL rnd_read a=%0d: got %h/%h want %h", a, rd0, rd3, exp_rd); end
      end
      n_cmp++; if (s0_after !== exp_s || s0_other !== 9'h0 || early_bad) begin
        n_err++; $display("FAIL rnd_strobe0 a=%0d: got %h (other %h, stray %b) want %h",
                          a, s0_after, s0_other, early_bad, exp_s); end
      if ($urandom_range(1, 0) == 1) begin
        idle_cycle();
        n_cmp++; if (s3_idle !== exp_s || s0_idle !== 9'h0 || idle_bad) begin
          n_err++; $display("FAIL rnd_strobe3 a=%0d: got %h (dut0 %h, stray %b) want %h",
                            a, s3_idle, s0_idle, idle_bad, exp_s); end
        n_cmp++; if (((regs0 & regs_mask()) !== (exp_regs() & regs_mask())) ||
                     ((regs3 & regs_mask()) !== (exp_regs() & regs_mask()))) begin
          n_err++; $display("FAIL rnd_regs: got %h / %h want %h", regs0, regs3, exp_regs()); end
      end
    end
    idle_cycle();
  endtask

  initial begin
    foreach (known[i]) known[i] = 1'b0;
    test_reset();
    test_width_trunc();
    test_byte_strobe();
    test_error();
    test_reset_abort();
    test_protocol_violation();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
